tcam_match_reader: RTL and testbench

TCAM_MATCH_READER -- requirements
Module: tcam_match_reader

---
 rtl/tcam_pkg.sv | 13 +
 rtl/tcam_prio_enc.sv | 31 +++
 rtl/tcam_match_reader.sv | 106 ++++++++++
 tb/tb_tcam_match_reader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared TCAM definitions: default geometry and the match-reader state encoding.
// Imported by the reader and the TCAM array top.
package tcam_pkg;

    localparam int unsigned TCAM_ENTRIES = 16;
    localparam int unsigned TCAM_ADDR_W  = 4;

    localparam int unsigned RDR_STATE_W  = 2;
    localparam logic [1:0]  RDR_IDLE     = 2'd0;
    localparam logic [1:0]  RDR_EMIT     = 2'd1;
    localparam logic [1:0]  RDR_MISS     = 2'd2;

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational priority encoder over the pending match vector: lowest set
// index, any-set flag and exactly-one-set flag.
module tcam_prio_enc
    import tcam_pkg::*;
#(
    parameter int unsigned ENTRIES = TCAM_ENTRIES,
    parameter int unsigned ADDR_W  = TCAM_ADDR_W
) (
    input  logic [ENTRIES-1:0] vec_i,
    output logic [ADDR_W-1:0]  idx_o,
    output logic               any_o,
    output logic               onehot_o
);

    // Scan high to low so the lowest set index wins.
    always_comb begin
        idx_o = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = ADDR_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when one bit was set.
    always_comb begin
        any_o    = |vec_i;
        onehot_o = any_o && ((vec_i & (vec_i - ENTRIES'(1))) == '0);
    end

endmodule

// File: rtl/tcam_match_reader.sv
// Serialises a TCAM match vector into a stream of matching entry indices,
// lowest index first, or a single miss pulse when nothing matched.
module tcam_match_reader
    import tcam_pkg::*;
#(
    parameter int unsigned ENTRIES = TCAM_ENTRIES,
    parameter int unsigned ADDR_W  = TCAM_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               match_valid,
    input  logic [ENTRIES-1:0] match_vec,
    output logic               match_ready,
    output logic               addr_valid,
    output logic [ADDR_W-1:0]  addr,
    output logic               addr_last,
    input  logic               addr_ready,
    output logic               miss,
    output logic [ADDR_W:0]    match_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [RDR_STATE_W-1:0] state_q, state_d;
    logic [ENTRIES-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ready_q, ready_d;

    logic [ADDR_W-1:0]      enc_idx;
    logic                   enc_any;
    logic                   enc_onehot;
    logic [ENTRIES-1:0]     clr_mask;

    tcam_prio_enc #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) u_prio_enc (
        .vec_i    (pending_q),
        .idx_o    (enc_idx),
        .any_o    (enc_any),
        .onehot_o (enc_onehot)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        clr_mask  = '0;
        clr_mask[enc_idx] = 1'b1;

        case (state_q)
            RDR_IDLE: begin
                if (match_valid && ready_q) begin
                    pending_d = match_vec;
                    count_d   = '0;
                    state_d   = (|match_vec) ? RDR_EMIT : RDR_MISS;
                end
            end
            RDR_EMIT: begin
                if (addr_ready && enc_any) begin
                    pending_d = pending_q & ~clr_mask;
                    count_d   = count_q + CNT_W'(1);
                    if (enc_onehot) begin
                        state_d = RDR_IDLE;
                    end
                end
            end
            RDR_MISS: begin
                state_d = RDR_IDLE;
            end
            default: begin
                state_d   = RDR_IDLE;
                pending_d = '0;
            end
        endcase

        // Held low through reset so ready first rises on the edge after release.
        ready_d = (state_d == RDR_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RDR_IDLE;
            pending_q <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
        end
    end

    // Outputs decode directly from registers; addr follows the registered pending.
    always_comb begin
        match_ready = ready_q;
        addr_valid  = (state_q == RDR_EMIT);
        addr        = enc_idx;
        addr_last   = (state_q == RDR_EMIT) && enc_onehot;
        miss        = (state_q == RDR_MISS);
        match_count = count_q;
    end

endmodule

// File: tb/tb_tcam_match_reader.sv
// Self-checking bench for tcam_match_reader: vector table, random searches
// against a queue-based reference, and hand-written reset / held-input cases.
module tb_tcam_match_reader;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned ADDR_W  = 4;

    logic               clk;
    logic               rst;
    logic               match_valid;
    logic [ENTRIES-1:0] match_vec;
    logic               match_ready;
    logic               addr_valid;
    logic [ADDR_W-1:0]  addr;
    logic               addr_last;
    logic               addr_ready;
    logic               miss;
    logic [ADDR_W:0]    match_count;

    int total;
    int bad;

    typedef struct {
        logic [ENTRIES-1:0] vec;
        int                 init_stall;
        int                 stall_pct;
        int                 exp_count;
    } vec_t;

    vec_t tbl[$];

    tcam_match_reader #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .match_valid (match_valid),
        .match_vec   (match_vec),
        .match_ready (match_ready),
        .addr_valid  (addr_valid),
        .addr        (addr),
        .addr_last   (addr_last),
        .addr_ready  (addr_ready),
        .miss        (miss),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One search: expected addresses are the set bits of vec in ascending order.
    task automatic do_search(input logic [ENTRIES-1:0] vec, input int init_stall,
                             input int stall_pct, output int emitted);
        int q[$];
        int cyc;
        int budget;
        logic rdy;
        for (int i = 0; i < int'(ENTRIES); i++) if (vec[i]) q.push_back(i);
        emitted = 0;

        budget = 0;
        while (!match_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("ready_before_accept", 32'(match_ready), 1);
        match_valid = 1'b1;
        match_vec   = vec;
        addr_ready  = 1'b0;
        @(negedge clk);
        match_valid = 1'b0;
        match_vec   = ENTRIES'($urandom);
        chk("count_cleared", 32'(match_count), 0);
        chk("ready_low_busy", 32'(match_ready), 0);

        if (q.size() == 0) begin
            chk("miss_pulse", 32'(miss), 1);
            chk("miss_no_valid", 32'(addr_valid), 0);
            @(negedge clk);
            chk("miss_one_cycle", 32'(miss), 0);
            chk("miss_no_valid_after", 32'(addr_valid), 0);
        end else begin
            cyc = 0;
            while (q.size() > 0) begin
                if (cyc > 400) begin
                    chk("emit_timeout", 1, 0);
                    break;
                end
                rdy = (cyc >= init_stall) && (int'($urandom_range(99)) >= stall_pct);
                chk("addr_valid", 32'(addr_valid), 1);
                chk("addr", 32'(addr), 32'(q[0]));
                chk("addr_last", 32'(addr_last), 32'(q.size() == 1));
                chk("miss_quiet", 32'(miss), 0);
                chk("count_running", 32'(match_count), 32'(emitted));
                addr_ready = rdy;
                @(negedge clk);
                if (rdy) begin
                    void'(q.pop_front());
                    emitted++;
                end
                cyc++;
            end
            addr_ready = 1'b0;
            chk("valid_after_last", 32'(addr_valid), 0);
        end
        chk("ready_after_search", 32'(match_ready), 1);
        chk("count_final", 32'(match_count), 32'(emitted));
    endtask

    initial begin
        int n;
        logic [ENTRIES-1:0] rv;
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        match_valid = 1'b0;
        match_vec   = '0;
        addr_ready  = 1'b0;

        // Reset state
        #3;
        chk("rst_ready", 32'(match_ready), 0);
        chk("rst_valid", 32'(addr_valid), 0);
        chk("rst_count", 32'(match_count), 0);
        chk("rst_miss", 32'(miss), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(match_ready), 1);

        tbl.push_back('{16'h0000, 0,  0,  0});
        tbl.push_back('{16'h8421, 0,  0,  4});
        tbl.push_back('{16'h0006, 3,  0,  2});
        tbl.push_back('{16'hFFFF, 0,  0, 16});
        tbl.push_back('{16'h0001, 0,  0,  1});
        tbl.push_back('{16'h8000, 2,  0,  1});
        tbl.push_back('{16'hFFFF, 1, 50, 16});
        tbl.push_back('{16'hA5A5, 0, 30,  8});
        for (int t = 0; t < tbl.size(); t++) begin
            do_search(tbl[t].vec, tbl[t].init_stall, tbl[t].stall_pct, n);
            chk($sformatf("tbl%0d_count", t), 32'(match_count), 32'(tbl[t].exp_count));
        end

        // Held match_valid during EMIT must wait for IDLE.
        @(negedge clk);
        match_valid = 1'b1;
        match_vec   = 16'h0030;
        @(negedge clk);
        match_vec   = 16'h0001;
        addr_ready  = 1'b1;
        chk("hold_addr4", 32'(addr), 4);
        chk("hold_last4", 32'(addr_last), 0);
        @(negedge clk);
        chk("hold_addr5", 32'(addr), 5);
        chk("hold_last5", 32'(addr_last), 1);
        @(negedge clk);
        chk("hold_idle_valid", 32'(addr_valid), 0);
        chk("hold_idle_count", 32'(match_count), 2);
        chk("hold_idle_ready", 32'(match_ready), 1);
        @(negedge clk);
        match_valid = 1'b0;
        chk("hold_addr0", 32'(addr), 0);
        chk("hold_valid0", 32'(addr_valid), 1);
        chk("hold_last0", 32'(addr_last), 1);
        chk("hold_count0", 32'(match_count), 0);
        @(negedge clk);
        chk("hold_final_count", 32'(match_count), 1);
        addr_ready = 1'b0;

        // Randomized searches
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(3))
                0:       rv = '0;
                1:       rv = ENTRIES'(1) << $urandom_range(ENTRIES - 1);
                2:       rv = ENTRIES'($urandom) & ENTRIES'($urandom);
                default: rv = ENTRIES'($urandom);
            endcase
            do_search(rv, int'($urandom_range(2)), int'($urandom_range(70)), n);
            chk("rand_count", 32'(n), 32'($countones(rv)));
        end

        // Reset mid-EMIT discards remaining matches.
        @(negedge clk);
        match_valid = 1'b1;
        match_vec   = 16'hFFFF;
        @(negedge clk);
        match_valid = 1'b0;
        addr_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(addr_valid), 0);
        chk("midrst_addr", 32'(addr), 0);
        chk("midrst_last", 32'(addr_last), 0);
        chk("midrst_count", 32'(match_count), 0);
        chk("midrst_ready", 32'(match_ready), 0);
        chk("midrst_miss", 32'(miss), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_ready", 32'(match_ready), 1);
            chk("postrst_valid", 32'(addr_valid), 0);
            chk("postrst_count", 32'(match_count), 0);
        end
        addr_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
